// File: rtl/ifu_pkg.sv
// Shared constants for the instruction fetch unit: CPU widths, OCP command and
// response encodings, and the fetch FSM state encoding.
package ifu_pkg;

    localparam int CPU_ADDR_WIDTH  = 32;
    localparam int CPU_INSTR_WIDTH = 32;

    typedef enum logic [2:0] {
        OCP_CMD_IDLE  = 3'd0,
        OCP_CMD_WRITE = 3'd1,
        OCP_CMD_READ  = 3'd2
    } ocp_cmd_t;

    typedef enum logic [1:0] {
        OCP_RESP_NULL = 2'd0,
        OCP_RESP_DVA  = 2'd1,
        OCP_RESP_FAIL = 2'd2,
        OCP_RESP_ERR  = 2'd3
    } ocp_resp_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_RESP = 2'd2
    } ifu_state_t;

    // A fetch address is word aligned when its two low bits are zero.
    function automatic logic is_aligned(input logic [1:0] lsb);
        return lsb == 2'b00;
    endfunction

endpackage

// File: rtl/ifu.sv
// Instruction fetch unit: turns single-word fetch requests into one OCP read
// at a time, flags misaligned requests and bus errors/timeouts, and returns
// the instruction word to fetch together with a combinational stall.
//
// Handshake: the fetch side issues a one-cycle i_rd_cmd; o_busy stays high
// until the cycle in which the response arrives, and o_instr_dat is valid in
// that same cycle. On the OCP side o_MCmd/o_MAddr are held until
// i_SCmdAccept=1; the response may come in the accept cycle or any later one.
module ifu
    import ifu_pkg::*;
#(
    parameter int RESP_TIMEOUT = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [CPU_ADDR_WIDTH-1:0]  i_addr,
    input  logic                       i_rd_cmd,
    output logic [CPU_INSTR_WIDTH-1:0] o_instr_dat,
    output logic                       o_busy,
    output logic                       o_err_align,
    output logic                       o_err_bus,
    output logic [CPU_ADDR_WIDTH-1:0]  o_MAddr,
    output logic [2:0]                 o_MCmd,
    output logic [31:0]                o_MData,
    output logic [3:0]                 o_MByteEn,
    input  logic                       i_SCmdAccept,
    input  logic [31:0]                i_SData,
    input  logic [1:0]                 i_SResp,
    output logic [1:0]                 o_dbg_state
);

    localparam int CNT_W = (RESP_TIMEOUT > 0) ? $clog2(RESP_TIMEOUT + 1) : 1;

    ifu_state_t                 state, state_nxt;
    logic [CPU_ADDR_WIDTH-1:0]  maddr_r;
    logic [CPU_INSTR_WIDTH-1:0] data_r;
    logic [CNT_W-1:0]           cnt_r;

    logic req_aligned;
    logic resp_null;
    logic resp_now;
    logic timeout_hit;
    logic done;
    logic done_dva;

    assign req_aligned = i_rd_cmd && is_aligned(i_addr[1:0]);
    assign resp_null   = (i_SResp == OCP_RESP_NULL);

    // A response counts only once the command has been accepted.
    assign resp_now = !resp_null &&
                      (((state == ST_CMD) && i_SCmdAccept) || (state == ST_RESP));

    generate
        if (RESP_TIMEOUT > 0) begin : g_timeout
            assign timeout_hit = (state == ST_RESP) && resp_null &&
                                 (cnt_r == CNT_W'(RESP_TIMEOUT));
        end else begin : g_no_timeout
            assign timeout_hit = 1'b0;
        end
    endgenerate

    assign done     = resp_now || timeout_hit;
    assign done_dva = resp_now && (i_SResp == OCP_RESP_DVA);

    // Next-state logic for the one-transaction-at-a-time fetch FSM.
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: if (req_aligned) state_nxt = ST_CMD;
            ST_CMD:  if (i_SCmdAccept) state_nxt = resp_null ? ST_RESP : ST_IDLE;
            ST_RESP: if (done) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State register; reset aborts any transaction in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // Bus address is captured from an aligned request accepted in IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                maddr_r <= '0;
        else if ((state == ST_IDLE) && req_aligned) maddr_r <= i_addr;
    end

    // Data register: read data on DVA, zero (NOP) on any error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            data_r <= '0;
        else if (done)
            data_r <= done_dva ? i_SData : '0;
        else if (o_err_align)
            data_r <= '0;
    end

    // Response-wait counter: zero outside RESP, counts NULL cycles inside it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                    cnt_r <= '0;
        else if (state != ST_RESP)  cnt_r <= '0;
        else if (resp_null)         cnt_r <= cnt_r + 1'b1;
    end

    assign o_MAddr     = maddr_r;
    assign o_MCmd      = (state == ST_CMD) ? OCP_CMD_READ : OCP_CMD_IDLE;
    assign o_MByteEn   = (state == ST_CMD) ? 4'hF : 4'h0;
    assign o_MData     = '0;
    assign o_err_align = (state == ST_IDLE) && i_rd_cmd && !is_aligned(i_addr[1:0]);
    assign o_err_bus   = done && !done_dva;
    assign o_busy      = req_aligned || ((state != ST_IDLE) && !done);
    assign o_instr_dat = done_dva ? i_SData : (done ? '0 : data_r);
    assign o_dbg_state = state;

endmodule
